// File: rtl/adc_input_write_bank.sv
// AXI4-Lite write-only register bank: NUM_REGS 32-bit registers with byte strobes,
// per-register write strobes and optional self-clearing (pulse) registers.
module adc_input_write_bank #(
    parameter int                     NUM_REGS   = 8,
    parameter int                     ADDR_W     = 8,
    parameter logic [NUM_REGS*32-1:0] RESET_VAL  = '0,
    parameter logic [NUM_REGS-1:0]    PULSE_MASK = NUM_REGS'(1)
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    input  logic [31:0]              AWADDR,
    input  logic                     AWVALID,
    output logic                     AWREADY,
    input  logic [31:0]              WDATA,
    input  logic [3:0]               WSTRB,
    input  logic                     WVALID,
    output logic                     WREADY,
    output logic [1:0]               BRESP,
    output logic                     BVALID,
    input  logic                     BREADY,
    output logic [NUM_REGS*32-1:0]   regs,
    output logic [NUM_REGS-1:0]      wr_stb
);

    localparam int         IDX_W       = ADDR_W - 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        RESP
    } state_t;

    state_t             state_q, state_d;
    logic               aw_held, w_held;
    logic [IDX_W-1:0]   idx_q;
    logic [31:0]        data_q;
    logic [3:0]         strb_q;
    logic [1:0]         bresp_q;
    logic               aw_hs, w_hs, b_hs, idx_valid;
    logic               unused_addr_bits;

    // Only AWADDR[ADDR_W-1:2] selects a register; the rest is deliberately ignored.
    assign unused_addr_bits = ^AWADDR;

    // Handshake outputs come from state decode and flops only, never from inputs.
    assign AWREADY = (state_q == IDLE) && !aw_held;
    assign WREADY  = (state_q == IDLE) && !w_held;
    assign BVALID  = (state_q == RESP);
    assign BRESP   = bresp_q;

    assign aw_hs     = AWVALID && AWREADY;
    assign w_hs      = WVALID && WREADY;
    assign b_hs      = BVALID && BREADY;
    assign idx_valid = 32'(idx_q) < 32'(NUM_REGS);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // NOTE: state_d gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if ((aw_held || aw_hs) && (w_held || w_hs)) state_d = WRITE;
            WRITE:   state_d = RESP;
            RESP:    if (BREADY) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
            strb_q  <= '0;
        end else begin
            if (aw_hs) begin
                aw_held <= 1'b1;
                idx_q   <= AWADDR[ADDR_W-1:2];
            end
            if (w_hs) begin
                w_held <= 1'b1;
                data_q <= WDATA;
                strb_q <= WSTRB;
            end
            if (b_hs) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
        end
    end

    // NOTE: the register array is reset on purpose; each entry is a control register
    // whose power-up value the datapath relies on, not storage that may start undefined.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            regs    <= RESET_VAL;
            wr_stb  <= '0;
            bresp_q <= RESP_OKAY;
        end else begin
            wr_stb <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                // Pulse registers fall back every cycle; a write below overrides the fallback.
                if (PULSE_MASK[i]) regs[32*i +: 32] <= RESET_VAL[32*i +: 32];
                if (state_q == WRITE && idx_q == IDX_W'(i)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (strb_q[b]) regs[32*i + 8*b +: 8] <= data_q[8*b +: 8];
                    end
                    wr_stb[i] <= 1'b1;
                end
            end
            if (state_q == WRITE) bresp_q <= idx_valid ? RESP_OKAY : RESP_SLVERR;
        end
    end

endmodule

// File: tb/tb_adc_input_write_bank.sv
// Directed bench for adc_input_write_bank: handshake orderings, byte strobes,
// out-of-range decode, pulse register, response back-pressure and reset abort.
module tb_adc_input_write_bank;

    localparam int NUM_REGS = 8;

    logic                   ACLK = 1'b0;
    logic                   ARESETN = 1'b0;
    logic [31:0]            AWADDR = '0;
    logic                   AWVALID = 1'b0;
    logic                   AWREADY;
    logic [31:0]            WDATA = '0;
    logic [3:0]             WSTRB = '0;
    logic                   WVALID = 1'b0;
    logic                   WREADY;
    logic [1:0]             BRESP;
    logic                   BVALID;
    logic                   BREADY = 1'b0;
    logic [NUM_REGS*32-1:0] regs;
    logic [NUM_REGS-1:0]    wr_stb;

    int errors = 0;
    int checks = 0;
    int stb_cycles = 0;
    int p0_cycles = 0;
    int bv_cycles = 0;
    logic [7:0]  stb_last = '0;
    logic [31:0] model [NUM_REGS];

    logic [1:0] resp;
    int         stb_n;
    logic [7:0] stb_v;
    int         p0_start;
    int         n;

    always #5 ACLK = ~ACLK;

    adc_input_write_bank dut (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .AWADDR  (AWADDR),
        .AWVALID (AWVALID),
        .AWREADY (AWREADY),
        .WDATA   (WDATA),
        .WSTRB   (WSTRB),
        .WVALID  (WVALID),
        .WREADY  (WREADY),
        .BRESP   (BRESP),
        .BVALID  (BVALID),
        .BREADY  (BREADY),
        .regs    (regs),
        .wr_stb  (wr_stb)
    );

    // Running counters sampled mid-cycle; tasks take deltas around each transaction.
    always @(negedge ACLK) begin
        if (wr_stb != '0) begin
            stb_cycles <= stb_cycles + 1;
            stb_last   <= wr_stb;
        end
        if (regs[31:0] != '0) p0_cycles <= p0_cycles + 1;
        if (BVALID) bv_cycles <= bv_cycles + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < NUM_REGS; i++)
            check($sformatf("%s_reg%0d", tag, i), 64'(regs[32*i +: 32]), 64'(model[i]));
    endtask

    // Entered and left on a falling edge with the bank idle. aw_delay/w_delay are the cycles
    // at which each channel is presented; bready_hold < 0 means BREADY is high from the start.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_delay, input int w_delay,
                             input int bready_hold, output logic [1:0] rsp,
                             output int stb_cnt, output logic [7:0] stb_val);
        int         last, wait_n, stb0, bv0;
        logic [1:0] r0;
        bit         stable;
        last   = (aw_delay > w_delay) ? aw_delay : w_delay;
        stb0   = stb_cycles;
        bv0    = bv_cycles;
        BREADY = (bready_hold < 0);
        for (int c = 0; c <= last; c++) begin
            if (c == aw_delay) begin AWADDR = addr; AWVALID = 1'b1; end
            if (c == w_delay) begin WDATA = data; WSTRB = strb; WVALID = 1'b1; end
            @(negedge ACLK);
            AWVALID = 1'b0;
            WVALID  = 1'b0;
            if (c == aw_delay && aw_delay < w_delay) begin
                check("aw_held_awready", 64'(AWREADY), 64'd0);
                check("aw_held_wready", 64'(WREADY), 64'd1);
            end
            if (c == w_delay && w_delay < aw_delay) begin
                check("w_held_wready", 64'(WREADY), 64'd0);
                check("w_held_awready", 64'(AWREADY), 64'd1);
            end
        end
        check("write_state_bvalid", 64'(BVALID), 64'd0);
        wait_n = 0;
        while (!BVALID && wait_n < 8) begin
            @(negedge ACLK);
            wait_n++;
        end
        check("b_latency", 64'(wait_n), 64'd1);
        rsp    = BRESP;
        r0     = BRESP;
        stable = 1'b1;
        if (bready_hold > 0) begin
            repeat (bready_hold) begin
                @(negedge ACLK);
                if (BVALID !== 1'b1 || BRESP !== r0 || AWREADY !== 1'b0 || WREADY !== 1'b0)
                    stable = 1'b0;
            end
            check("b_hold_stable", 64'(stable), 64'd1);
        end
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
        check("b_done_bvalid", 64'(BVALID), 64'd0);
        check("idle_awready", 64'(AWREADY), 64'd1);
        check("idle_wready", 64'(WREADY), 64'd1);
        @(negedge ACLK);
        stb_cnt = stb_cycles - stb0;
        stb_val = stb_last;
        check("bvalid_cycles", 64'(bv_cycles - bv0),
              64'((bready_hold > 0) ? bready_hold + 1 : 1));
    endtask

    initial begin
        for (int i = 0; i < NUM_REGS; i++) model[i] = '0;

        // Reset state
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        check("rst_awready", 64'(AWREADY), 64'd1);
        check("rst_wready", 64'(WREADY), 64'd1);
        check("rst_bvalid", 64'(BVALID), 64'd0);
        check("rst_bresp", 64'(BRESP), 64'd0);
        check("rst_wr_stb", 64'(wr_stb), 64'd0);
        check_regs("rst");
        ARESETN = 1'b1;
        @(negedge ACLK);

        // AW and W together, cycle-exact latency
        AWADDR = 32'h04; AWVALID = 1'b1;
        WDATA = 32'hDEADBEEF; WSTRB = 4'hF; WVALID = 1'b1;
        @(negedge ACLK);
        AWVALID = 1'b0; WVALID = 1'b0;
        check("t1_write_awready", 64'(AWREADY), 64'd0);
        check("t1_write_wready", 64'(WREADY), 64'd0);
        check("t1_write_stb", 64'(wr_stb), 64'd0);
        check("t1_write_reg1_old", 64'(regs[63:32]), 64'd0);
        @(negedge ACLK);
        check("t1_reg1", 64'(regs[63:32]), 64'hDEADBEEF);
        check("t1_stb", 64'(wr_stb), 64'h02);
        check("t1_bvalid", 64'(BVALID), 64'd1);
        check("t1_bresp", 64'(BRESP), 64'd0);
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
        check("t1_stb_cleared", 64'(wr_stb), 64'd0);
        check("t1_bvalid_done", 64'(BVALID), 64'd0);
        check("t1_awready_back", 64'(AWREADY), 64'd1);
        model[1] = 32'hDEADBEEF;
        check_regs("t1");

        // Preload reg 2, then W five cycles after AW with partial strobes
        axi_write(32'h08, 32'hAAAAAAAA, 4'hF, 0, 0, 0, resp, stb_n, stb_v);
        model[2] = 32'hAAAAAAAA;
        check("pre2_resp", 64'(resp), 64'd0);
        axi_write(32'h08, 32'h12345678, 4'h3, 0, 5, 0, resp, stb_n, stb_v);
        model[2] = 32'hAAAA5678;
        check("gap_resp", 64'(resp), 64'd0);
        check("gap_stb_n", 64'(stb_n), 64'd1);
        check("gap_stb_v", 64'(stb_v), 64'h04);
        check_regs("gap");

        // W before AW, single byte lane
        axi_write(32'h0C, 32'h11223344, 4'h2, 3, 0, 0, resp, stb_n, stb_v);
        model[3] = 32'h00003300;
        check("wfirst_resp", 64'(resp), 64'd0);
        check("wfirst_stb_n", 64'(stb_n), 64'd1);
        check("wfirst_stb_v", 64'(stb_v), 64'h08);
        check_regs("wfirst");

        // Out of range: first index past the bank and the top of the decode space
        axi_write(32'h20, 32'hFFFFFFFF, 4'hF, 0, 0, 0, resp, stb_n, stb_v);
        check("oor20_resp", 64'(resp), 64'h2);
        check("oor20_stb_n", 64'(stb_n), 64'd0);
        check_regs("oor20");
        axi_write(32'hFC, 32'hFFFFFFFF, 4'hF, 1, 0, 0, resp, stb_n, stb_v);
        check("oorfc_resp", 64'(resp), 64'h2);
        check("oorfc_stb_n", 64'(stb_n), 64'd0);
        check_regs("oorfc");

        // Zero strobes: nothing changes but the strobe still fires
        axi_write(32'h0C, 32'hFFFFFFFF, 4'h0, 0, 0, 0, resp, stb_n, stb_v);
        check("strb0_resp", 64'(resp), 64'd0);
        check("strb0_stb_n", 64'(stb_n), 64'd1);
        check("strb0_stb_v", 64'(stb_v), 64'h08);
        check_regs("strb0");

        // Low address bits and bits above ADDR_W ignored: 0x117 decodes to reg 5
        axi_write(32'h117, 32'hCAFEF00D, 4'hF, 0, 0, 0, resp, stb_n, stb_v);
        model[5] = 32'hCAFEF00D;
        check("lsb_resp", 64'(resp), 64'd0);
        check("lsb_stb_v", 64'(stb_v), 64'h20);
        check_regs("lsb");

        // Pulse register 0: visible for exactly one cycle
        p0_start = p0_cycles;
        axi_write(32'h00, 32'h00000001, 4'hF, 0, 0, 0, resp, stb_n, stb_v);
        check("pulse_cycles", 64'(p0_cycles - p0_start), 64'd1);
        check("pulse_stb_v", 64'(stb_v), 64'h01);
        check_regs("pulse");

        // Back-pressure on B for ten cycles, then BREADY already high
        axi_write(32'h18, 32'h600DF00D, 4'hF, 0, 0, 10, resp, stb_n, stb_v);
        model[6] = 32'h600DF00D;
        check("hold_resp", 64'(resp), 64'd0);
        axi_write(32'h1C, 32'h00000077, 4'h1, 0, 0, -1, resp, stb_n, stb_v);
        model[7] = 32'h00000077;
        check("bready_hi_resp", 64'(resp), 64'd0);
        check_regs("bp");

        // Reset while in RESP aborts the transaction
        AWADDR = 32'h10; AWVALID = 1'b1;
        WDATA = 32'h00000044; WSTRB = 4'hF; WVALID = 1'b1;
        @(negedge ACLK);
        AWVALID = 1'b0; WVALID = 1'b0;
        n = 0;
        while (!BVALID && n < 8) begin
            @(negedge ACLK);
            n++;
        end
        check("abort_reach_resp", 64'(BVALID), 64'd1);
        ARESETN = 1'b0;
        @(negedge ACLK);
        for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
        check("abort_bvalid", 64'(BVALID), 64'd0);
        check("abort_bresp", 64'(BRESP), 64'd0);
        check("abort_awready", 64'(AWREADY), 64'd1);
        check("abort_wready", 64'(WREADY), 64'd1);
        check("abort_stb", 64'(wr_stb), 64'd0);
        check_regs("abort");
        ARESETN = 1'b1;
        @(negedge ACLK);
        check("abort_no_resp", 64'(BVALID), 64'd0);

        // Bank accepts a fresh write after the abort
        axi_write(32'h04, 32'h00000001, 4'hF, 0, 0, 0, resp, stb_n, stb_v);
        model[1] = 32'h00000001;
        check("post_resp", 64'(resp), 64'd0);
        check_regs("post");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
